// File: rtl/cordic_prerotate_if.sv
// Sample stream into and out of the CORDIC pre-rotation block, with valid/ready on both sides.
interface cordic_prerotate_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] xi;
  logic signed [DATA_WIDTH-1:0] yi;
  logic signed [DATA_WIDTH-1:0] zi;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] xo;
  logic signed [DATA_WIDTH-1:0] yo;
  logic signed [DATA_WIDTH-1:0] zo;
  logic [1:0]                   qo;

  modport slave (
    input  in_valid, xi, yi, zi, out_ready,
    output in_ready, out_valid, xo, yo, zo, qo
  );

  modport master (
    output in_valid, xi, yi, zi, out_ready,
    input  in_ready, out_valid, xo, yo, zo, qo
  );
endinterface

// File: rtl/cordic_prerotate.sv
// Folds a full-circle angle into [-pi/2,+pi/2] by +/-pi/2 vector rotation; optional gain stage via CORDIC_PREROTATE_GAIN_COMP_EN.
// Latency 2 cycles (3 with gain stage); a full pipeline with out_ready low holds every sample and deasserts in_ready.
module cordic_prerotate #(
  parameter int DATA_WIDTH = 16
) (
  input logic               clk,
  input logic               reset_n,
  cordic_prerotate_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int ZW = DATA_WIDTH + 2;
  localparam int PI_2_I = int'(1.5707963267948966 * (2.0 ** (DW - 3)));

  localparam logic signed [ZW-1:0] PI_Z     = ZW'(2 * PI_2_I);
  localparam logic signed [DW-1:0] PI_2_D   = DW'(PI_2_I);
  localparam logic signed [DW-1:0] TWO_PI_D = DW'(4 * PI_2_I);
  localparam logic signed [DW-1:0] MAX_D    = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_D    = {1'b1, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
    return (v == MIN_D) ? MAX_D : -v;
  endfunction

  logic                 s1_vld, s2_vld;
  logic                 s1_rdy, s2_rdy, down_rdy;
  logic signed [DW-1:0] s1_x, s1_y, s1_z;
  logic signed [DW-1:0] s2_x, s2_y, s2_z;
  logic [1:0]           s2_q;

  // Compare in two extra bits so out-of-range angles are detected without overflow;
  // the wrapped result always fits DW bits, so the subtraction itself can stay narrow.
  logic signed [ZW-1:0] zi_e;
  logic signed [DW-1:0] z_wrap;
  assign zi_e = {{2{bus.zi[DW-1]}}, bus.zi};

  always_comb begin
    z_wrap = bus.zi;
    if (zi_e > PI_Z)
      z_wrap = bus.zi - TWO_PI_D;
    else if (zi_e < -PI_Z)
      z_wrap = bus.zi + TWO_PI_D;
  end

  logic signed [DW-1:0] x2_n, y2_n, z2_n, z2_sh;
  logic [1:0]           q2_n;

  always_comb begin
    x2_n = s1_x;
    y2_n = s1_y;
    z2_n = s1_z;
    q2_n = 2'b00;
    if (s1_z > PI_2_D) begin
      x2_n = neg_sat(s1_y);
      y2_n = s1_x;
      z2_n = s1_z - PI_2_D;
      q2_n = 2'b01;
    end else if (s1_z < -PI_2_D) begin
      x2_n = s1_y;
      y2_n = neg_sat(s1_x);
      z2_n = s1_z + PI_2_D;
      q2_n = 2'b10;
    end
  end

  assign z2_sh  = z2_n <<< 1;
  assign s2_rdy = !s2_vld || down_rdy;
  assign s1_rdy = !s1_vld || s2_rdy;
  assign bus.in_ready = s1_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_z   <= '0;
    end else if (s1_rdy) begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_x <= bus.xi;
        s1_y <= bus.yi;
        s1_z <= z_wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld <= 1'b0;
      s2_x   <= '0;
      s2_y   <= '0;
      s2_z   <= '0;
      s2_q   <= '0;
    end else if (s2_rdy) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_x <= x2_n;
        s2_y <= y2_n;
        s2_z <= z2_sh;
        s2_q <= q2_n;
      end
    end
  end

`ifdef CORDIC_PREROTATE_GAIN_COMP_EN
  localparam int PW = 2 * DW;
  localparam logic signed [PW-1:0] GAIN = PW'(int'(0.607253 * (2.0 ** (DW - 1))));
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (DW - 2));

  logic                 s3_vld, s3_rdy;
  logic signed [DW-1:0] s3_x, s3_y, s3_z;
  logic [1:0]           s3_q;
  logic signed [PW-1:0] x_ext, y_ext;

  assign x_ext    = {{DW{s2_x[DW-1]}}, s2_x};
  assign y_ext    = {{DW{s2_y[DW-1]}}, s2_y};
  assign s3_rdy   = !s3_vld || bus.out_ready;
  assign down_rdy = s3_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_vld <= 1'b0;
      s3_x   <= '0;
      s3_y   <= '0;
      s3_z   <= '0;
      s3_q   <= '0;
    end else if (s3_rdy) begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_x <= DW'((x_ext * GAIN + RND) >>> (DW - 1));
        s3_y <= DW'((y_ext * GAIN + RND) >>> (DW - 1));
        s3_z <= s2_z;
        s3_q <= s2_q;
      end
    end
  end

  assign bus.out_valid = s3_vld;
  assign bus.xo        = s3_x;
  assign bus.yo        = s3_y;
  assign bus.zo        = s3_z;
  assign bus.qo        = s3_q;
`else
  assign down_rdy      = bus.out_ready;
  assign bus.out_valid = s2_vld;
  assign bus.xo        = s2_x;
  assign bus.yo        = s2_y;
  assign bus.zo        = s2_z;
  assign bus.qo        = s2_q;
`endif
endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed-vector bench for cordic_prerotate: reset, quadrant folding, saturation, backpressure, mid-stream reset, gain path.
module tb_cordic_prerotate;
  localparam int DW = 16;
`ifdef CORDIC_PREROTATE_GAIN_COMP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cordic_prerotate_if #(.DATA_WIDTH(DW)) bus ();
  cordic_prerotate #(.DATA_WIDTH(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic signed [15:0] x, y, z, ex, ey, ez;
    logic [1:0]         eq;
  } vec_t;

  // Expected x/y after the optional gain stage (identity when it is not built).
  function automatic logic signed [15:0] gain(input logic signed [15:0] v);
`ifdef CORDIC_PREROTATE_GAIN_COMP_EN
    longint p;
    p = longint'(v) * 19898 + 16384;
    return 16'(p >>> 15);
`else
    return v;
`endif
  endfunction

  task automatic apply(input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic signed [15:0] z);
    bus.in_valid = 1'b1;
    bus.xi = x;
    bus.yi = y;
    bus.zi = z;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.xi = '0;
    bus.yi = '0;
    bus.zi = '0;
    #2;
    checks += 6;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.xo !== 16'sd0) begin failures++; $display("FAIL reset_xo: got %0d expected 0", bus.xo); end
    if (bus.yo !== 16'sd0) begin failures++; $display("FAIL reset_yo: got %0d expected 0", bus.yo); end
    if (bus.zo !== 16'sd0) begin failures++; $display("FAIL reset_zo: got %0d expected 0", bus.zo); end
    if (bus.qo !== 2'b00) begin failures++; $display("FAIL reset_qo: got %b expected 00", bus.qo); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_quadrants;
    vec_t v[9];
    v[0] = '{16384, 0, 6434, 16384, 0, 12868, 2'b00};
    v[1] = '{16384, 0, 19302, 0, 16384, 12868, 2'b01};
    v[2] = '{16384, 0, -25736, 0, -16384, -25736, 2'b10};
    v[3] = '{1000, 2000, 28000, 2000, -1000, -21208, 2'b10};
    v[4] = '{-32768, 5, -19302, 5, 32767, -12868, 2'b10};
    v[5] = '{100, 200, 12868, 100, 200, 25736, 2'b00};
    v[6] = '{100, 200, -12868, 100, 200, -25736, 2'b00};
    v[7] = '{300, -400, -28000, 400, 300, 21208, 2'b01};
    v[8] = '{7, -32768, 25736, 32767, 7, 25736, 2'b01};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      apply(v[i].x, v[i].y, v[i].z);
      for (int k = 1; k < LAT; k++) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_early_valid: got %b expected 0", i, bus.out_valid); end
        @(negedge clk);
      end
      checks += 5;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL vec%0d_valid: got %b expected 1", i, bus.out_valid); end
      if (bus.xo !== gain(v[i].ex)) begin failures++; $display("FAIL vec%0d_xo: got %0d expected %0d", i, bus.xo, gain(v[i].ex)); end
      if (bus.yo !== gain(v[i].ey)) begin failures++; $display("FAIL vec%0d_yo: got %0d expected %0d", i, bus.yo, gain(v[i].ey)); end
      if (bus.zo !== v[i].ez) begin failures++; $display("FAIL vec%0d_zo: got %0d expected %0d", i, bus.zo, v[i].ez); end
      if (bus.qo !== v[i].eq) begin failures++; $display("FAIL vec%0d_qo: got %b expected %b", i, bus.qo, v[i].eq); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int recv = 0;
    int stalls = 0;
    int cyc = 0;
    logic in_fire;
    logic holding = 1'b0;
    logic signed [15:0] held_x = '0;
    while (recv < 8 && cyc < 60) begin
      bus.in_valid = (sent < 8);
      bus.xi = 16'(sent * 100 + 1);
      bus.yi = 16'(sent);
      bus.zi = '0;
      bus.out_ready = !(cyc >= 3 && cyc < 8);
      #1;
      if (!bus.in_ready) stalls++;
      if (!bus.in_ready && bus.out_ready) begin
        checks++; failures++;
        $display("FAIL bp_in_ready_low_unstalled: got 0 expected 1 at cycle %0d", cyc);
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (holding) begin
          checks++;
          if (bus.xo !== held_x) begin failures++; $display("FAIL bp_hold_xo: got %0d expected %0d", bus.xo, held_x); end
        end
        held_x = bus.xo;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks += 2;
        if (bus.xo !== gain(16'(recv * 100 + 1))) begin failures++; $display("FAIL bp_order_xo%0d: got %0d expected %0d", recv, bus.xo, gain(16'(recv * 100 + 1))); end
        if (bus.yo !== gain(16'(recv))) begin failures++; $display("FAIL bp_order_yo%0d: got %0d expected %0d", recv, bus.yo, gain(16'(recv))); end
        recv++;
      end
      in_fire = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (in_fire) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks += 3;
    if (recv != 8) begin failures++; $display("FAIL bp_received: got %0d expected 8", recv); end
    if (sent != 8) begin failures++; $display("FAIL bp_sent: got %0d expected 8", sent); end
    if (stalls != 5) begin failures++; $display("FAIL bp_stall_cycles: got %0d expected 5", stalls); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra_output: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream;
    bus.out_ready = 1'b0;
    apply(16'sd1111, 16'sd2222, 16'sd0);
    apply(16'sd3333, 16'sd4444, 16'sd19302);
    #2;
    reset_n = 1'b0;
    #1;
    checks += 6;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
    if (bus.xo !== 16'sd0) begin failures++; $display("FAIL midrst_xo: got %0d expected 0", bus.xo); end
    if (bus.yo !== 16'sd0) begin failures++; $display("FAIL midrst_yo: got %0d expected 0", bus.yo); end
    if (bus.zo !== 16'sd0) begin failures++; $display("FAIL midrst_zo: got %0d expected 0", bus.zo); end
    if (bus.qo !== 2'b00) begin failures++; $display("FAIL midrst_qo: got %b expected 00", bus.qo); end
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    apply(16'sd16384, 16'sd0, 16'sd19302);
    for (int k = 1; k < LAT; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale_valid: got %b expected 0", bus.out_valid); end
      @(negedge clk);
    end
    checks += 4;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_next_valid: got %b expected 1", bus.out_valid); end
    if (bus.yo !== gain(16'sd16384)) begin failures++; $display("FAIL midrst_next_yo: got %0d expected %0d", bus.yo, gain(16'sd16384)); end
    if (bus.zo !== 16'sd12868) begin failures++; $display("FAIL midrst_next_zo: got %0d expected 12868", bus.zo); end
    if (bus.qo !== 2'b01) begin failures++; $display("FAIL midrst_next_qo: got %b expected 01", bus.qo); end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_gain_path;
    logic signed [15:0] ex, ey;
`ifdef CORDIC_PREROTATE_GAIN_COMP_EN
    ex = 16'sd9949;
    ey = -16'sd9949;
`else
    ex = 16'sd16384;
    ey = -16'sd16384;
`endif
    bus.out_ready = 1'b1;
    apply(16'sd16384, -16'sd16384, 16'sd0);
    for (int k = 1; k < LAT; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gain_early_valid: got %b expected 0", bus.out_valid); end
      @(negedge clk);
    end
    checks += 5;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL gain_valid: got %b expected 1", bus.out_valid); end
    if (bus.xo !== ex) begin failures++; $display("FAIL gain_xo: got %0d expected %0d", bus.xo, ex); end
    if (bus.yo !== ey) begin failures++; $display("FAIL gain_yo: got %0d expected %0d", bus.yo, ey); end
    if (bus.zo !== 16'sd0) begin failures++; $display("FAIL gain_zo: got %0d expected 0", bus.zo); end
    if (bus.qo !== 2'b00) begin failures++; $display("FAIL gain_qo: got %b expected 00", bus.qo); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_back_to_back();
    test_reset_midstream();
    test_gain_path();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_prerotate.md
CORDIC_PREROTATE -- requirements
Module: cordic_prerotate

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, setting the width of the x/y/z data paths; all angle constants scale with it.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream sample valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-006 The block SHALL have ports xi and yi, input, DATA_WIDTH bits each, signed vector coordinates.
REQ-007 The block SHALL have port zi, input, DATA_WIDTH bits, signed angle in Q3.(DATA_WIDTH-3) radians, full circle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: output sample valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream rotation-mode CORDIC pipeline enable/accept.
REQ-010 The block SHALL have ports xo and yo, output, DATA_WIDTH bits each, signed pre-rotated coordinates.
REQ-011 The block SHALL have port zo, output, DATA_WIDTH bits, signed residual angle in Q2.(DATA_WIDTH-2), within [-pi/2, +pi/2].
REQ-012 The block SHALL have port qo, output, 2 bits: 00 no pre-rotation, 01 +pi/2 applied, 10 -pi/2 applied.

Function
REQ-013 Constants SHALL be PI_2 = round(pi/2 * 2^(DATA_WIDTH-3)) and PI and TWO_PI as exact multiples of PI_2 (DATA_WIDTH=16: 12868, 25736, 51472).
REQ-014 A transfer SHALL occur on any cycle with in_valid and in_ready both high; likewise out_valid and out_ready.
REQ-015 Stage 1 SHALL wrap the angle using DATA_WIDTH+2-bit signed arithmetic: if zi > PI subtract TWO_PI; if zi < -PI add TWO_PI; otherwise pass unchanged.
REQ-016 Stage 2: if wrapped z > PI_2, SHALL output x = -y, y = x, z = z - PI_2, q = 01.
REQ-017 Stage 2: if wrapped z < -PI_2, SHALL output x = y, y = -x, z = z + PI_2, q = 10.
REQ-018 Stage 2: otherwise SHALL pass x, y, z unchanged with q = 00; z = +/-PI_2 exactly SHALL NOT rotate.
REQ-019 Negating the most negative value SHALL saturate to the most positive value (0x7FFF at 16 bits).
REQ-020 The stage 2 residual z SHALL be left-shifted by 1 to Q2.(DATA_WIDTH-2) and cannot overflow.
REQ-021 Each pipeline stage SHALL hold a valid bit and SHALL load when empty or when its contents advance in the same cycle.
REQ-022 in_ready SHALL equal NOT stage1_valid OR stage1 advancing; a full pipeline with out_ready low SHALL hold all data unchanged and drop nothing.
REQ-023 Latency SHALL be 2 cycles from input transfer to out_valid (3 with GAIN_COMP_EN), and throughput one sample per cycle while out_ready is high.
REQ-024 Data registers SHALL load only on stage advance, never while stalled.

Reset
REQ-025 While reset_n is low, all valid bits SHALL be 0 and xo, yo, zo and qo SHALL be 0, independent of clk.
REQ-026 in_ready SHALL be 1 during and after reset; out_valid SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight samples; the first input after release SHALL appear after the normal latency.

Configuration
REQ-028 With macro CORDIC_PREROTATE_GAIN_COMP_EN defined, a third stage SHALL scale xo and yo by round(0.607253 * 2^(DATA_WIDTH-1)) (19898 at 16 bits): full-width signed product, add 2^(DATA_WIDTH-2), arithmetic shift right DATA_WIDTH-1; zo and qo SHALL pass through delayed one cycle.
REQ-029 Without CORDIC_PREROTATE_GAIN_COMP_EN, the third stage SHALL be absent, x/y SHALL be unscaled, and latency SHALL be 2.

Verification
REQ-030 xi=16384, yi=0, zi=6434 (pi/4), macro off -> after 2 cycles xo=16384, yo=0, zo=12868, qo=00.
REQ-031 xi=16384, yi=0, zi=19302 (3pi/4) -> xo=0, yo=16384, zo=12868, qo=01; zi=-25736 -> xo=0, yo=-16384, zo=-25736, qo=10.
REQ-032 zi=28000 -> wrapped to -23472, then xo=yi, yo=-xi, zo=-21208, qo=10; xi=-32768 with a negating branch -> 32767.
REQ-033 Continuous in_valid, 8 samples, out_ready low 5 cycles mid-stream -> in_ready drops once 2 stages are full, and all 8 samples emerge in order with none duplicated or lost.
REQ-034 Macro on, xi=16384, yi=-16384, zi=0 -> after 3 cycles xo=9949, yo=-9949, zo=0.
REQ-035 reset_n pulsed low with 2 samples in flight -> out_valid=0 immediately and outputs 0; the next sample appears after exact latency.
